// File: rtl/afifo_arb_pkg.sv
// Shared types and widths for the AFIFO write-port arbiter.
package afifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned BEAT_W = 8;
  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/afifo_wr_arbiter_rr_pick.sv
// Round-robin winner search: first set request above last_gnt, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_gnt,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_gnt) + k) % NREQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// N-to-1 burst arbiter in front of an async FIFO write port.
// Optional per-requester beat statistics enabled by AFIFO_ARB_STATS_EN.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 fifo_wren,
  output logic [DW-1:0]        fifo_wdata,
  input  logic                 fifo_wfull,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
`ifdef AFIFO_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] stat_beats
`endif
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pick_any;
  logic [IDW-1:0]    pick_idx;
  logic              own_valid;
  logic              own_last;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req      (req_valid),
    .last_gnt (last_q),
    .any      (pick_any),
    .winner   (pick_idx)
  );

  // Owner's valid/last/data, selected with no added latency.
  always_comb begin
    own_valid  = 1'b0;
    own_last   = 1'b0;
    fifo_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        own_valid  = req_valid[i];
        own_last   = req_last[i];
        fifo_wdata = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    req_ready = '0;
    fifo_wren = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          req_ready[i] = (grant_q == IDW'(i)) && !fifo_wfull;
        end
        fifo_wren = own_valid && !fifo_wfull;
        // A full FIFO only stalls; release needs a counted beat or a dropped valid.
        if (!own_valid) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (fifo_wren) begin
          beat_d = beat_q + BEAT_W'(1);
          if (own_last || (beat_q == BEAT_W'(BURST - 1))) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT);

`ifdef AFIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NREQ];
  logic [STAT_W-1:0] stat_d [NREQ];

  // Saturating accepted-beat counters, one per requester.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_d[i] = stat_q[i];
      if (fifo_wren && (grant_q == IDW'(i)) && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) stat_q[i] <= stat_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed scoreboard bench for afifo_wr_arbiter (NREQ=4, DW=8, BURST=4).
module tb_afifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_wren;
  logic [7:0]  fifo_wdata;
  logic        fifo_wfull;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef AFIFO_ARB_STATS_EN
  logic [63:0] stat_beats;
`endif

  typedef struct {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t        sbq[$];
  int unsigned seq[4];
  int          n_cmp;
  int          n_bad;
  int          wr_cnt;
  int          wr_base;

  afifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef AFIFO_ARB_STATS_EN
    ,
    .stat_beats (stat_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input int unsigned d);
    exp_t e;
    e.id = 2'(id);
    e.d  = 8'(d);
    sbq.push_back(e);
  endtask

  task automatic update_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i*16 + int'(seq[i]));
  endtask

  // One clock: settle, score any FIFO write, advance accepted requesters.
  task automatic tick();
    logic [3:0] acc;
    exp_t       e;
    update_data();
    #1;
    if (fifo_wren) begin
      wr_cnt++;
      n_cmp++;
      assert (sbq.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_underflow observed=write id %0d expected=no write", grant_id);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_id", 32'(grant_id), 32'(e.id));
        chk("sb_data", 32'(fifo_wdata), 32'(e.d));
      end
    end
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) seq[i]++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_last   = 4'b0000;
    fifo_wfull = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    sbq.delete();
    update_data();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_wren", 32'(fifo_wren), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    rst       = 1'b0;
    wr_base   = wr_cnt;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    wr_cnt = 0;
    req_data = '0;

    // Single-beat packet from requester 0.
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    push(0, 8'h00);
    tick();
    chk("p1_busy", 32'(busy), 32'd1);
    chk("p1_grant", 32'(grant_id), 32'd0);
    tick();
    chk("p1_idle", 32'(busy), 32'd0);
    req_valid = 4'b0000;
    tick();
    tick();
    chk("p1_writes", 32'(wr_cnt - wr_base), 32'd1);

    // All requesters valid, no last: grants 0,1,2,3,0 with 4 beats each.
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b0000;
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++) push(g % 4, (g % 4) * 16 + (g / 4) * 4 + b);
    for (int c = 0; c < 25; c++) begin
      chk("rr_busy", 32'(busy), (c % 5 != 0) ? 32'd1 : 32'd0);
      if (c % 5 != 0) chk("rr_grant", 32'(grant_id), 32'((c / 5) % 4));
      tick();
    end
    req_valid = 4'b0000;
    chk("rr_idle_end", 32'(busy), 32'd0);
    tick();
    chk("rr_writes", 32'(wr_cnt - wr_base), 32'd20);
    chk("rr_sb_drain", 32'(sbq.size()), 32'd0);
`ifdef AFIFO_ARB_STATS_EN
    chk("stat0", 32'(stat_beats[15:0]), 32'd8);
    chk("stat1", 32'(stat_beats[31:16]), 32'd4);
    chk("stat2", 32'(stat_beats[47:32]), 32'd4);
    chk("stat3", 32'(stat_beats[63:48]), 32'd4);
`endif

    // Requester 2 stalled by a full FIFO for 5 cycles mid-burst.
    do_reset();
    req_valid = 4'b0100;
    for (int b = 0; b < 4; b++) push(2, 32 + b);
    tick();
    chk("st_grant", 32'(grant_id), 32'd2);
    tick();
    tick();
    fifo_wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("st_wren", 32'(fifo_wren), 32'd0);
      chk("st_ready", 32'(req_ready), 32'd0);
      chk("st_busy", 32'(busy), 32'd1);
      chk("st_hold", 32'(grant_id), 32'd2);
      tick();
    end
    fifo_wfull = 1'b0;
    tick();
    chk("st_mid", 32'(busy), 32'd1);
    tick();
    chk("st_release", 32'(busy), 32'd0);
    req_valid = 4'b0000;
    chk("st_writes", 32'(wr_cnt - wr_base), 32'd4);

    // Requester 1 drops valid after 2 beats; requester 3 is next above 1.
    do_reset();
    req_valid = 4'b1010;
    tick();
    chk("dv_grant", 32'(grant_id), 32'd1);
    req_valid = 4'b1011;
    push(1, 16);
    push(1, 17);
    #1;
    chk("dv_ready", 32'(req_ready), 32'b0010);
    tick();
    tick();
    req_valid = 4'b1001;
    #1;
    chk("dv_nowren", 32'(fifo_wren), 32'd0);
    tick();
    chk("dv_release", 32'(busy), 32'd0);
    req_last = 4'b1000;
    push(3, 48);
    tick();
    chk("dv_next", 32'(grant_id), 32'd3);
    chk("dv_next_busy", 32'(busy), 32'd1);
    tick();
    req_valid = 4'b0000;
    chk("dv_writes", 32'(wr_cnt - wr_base), 32'd3);

    // Reset during the second beat of a grant to requester 3.
    do_reset();
    req_valid = 4'b1000;
    push(3, 48);
    tick();
    tick();
    update_data();
    #1;
    chk("ra_wren_pre", 32'(fifo_wren), 32'd1);
    rst = 1'b1;
    #1;
    chk("ra_wren", 32'(fifo_wren), 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_ready", 32'(req_ready), 32'd0);
    chk("ra_grant", 32'(grant_id), 32'd0);
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    @(posedge clk);
    #1;
    chk("ra_held_wren", 32'(fifo_wren), 32'd0);
    rst = 1'b0;
    tick();
    chk("ra_first", 32'(grant_id), 32'd0);
    chk("ra_first_busy", 32'(busy), 32'd1);
    push(0, seq[0]);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("ra_sb_drain", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arbiter.md
AFIFO_WR_ARBITER -- requirements
Module: afifo_wr_arbiter

Interface
- REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one AFIFO write port.
- REQ-002 The block SHALL have parameter DW, default 8: data width, equal to the FIFO dsize.
- REQ-003 The block SHALL have parameter BURST, default 4: maximum beats per grant, range 1..255.
- REQ-004 The block SHALL have ports in this order:
  - clk  in  1  single clock, the FIFO write clock.
  - rst  in  1  asynchronous active-high reset.
  - req_valid  in  NREQ  per-requester data valid.
  - req_data  in  NREQ*DW  requester i occupies bits [i*DW +: DW].
  - req_last  in  NREQ  marks the final beat of a packet.
  - req_ready  out  NREQ  per-requester accept.
  - fifo_wren  out  1  FIFO write enable.
  - fifo_wdata  out  DW  FIFO write data.
  - fifo_wfull  in  1  FIFO full flag.
  - grant_id  out  clog2(NREQ)  current owner.
  - busy  out  1  high in GRANT.

Function
- REQ-005 The block SHALL implement a two-state FSM, IDLE and GRANT.
- REQ-006 In IDLE with any req_valid high, the FSM SHALL choose a winner round-robin, searching from last_gnt+1 upward with wrap, register it into grant_id, and enter GRANT on the next edge. The grant therefore takes one cycle.
- REQ-007 In IDLE with no req_valid high, the FSM SHALL stay in IDLE, and grant_id SHALL hold its value.
- REQ-008 In GRANT:
  - req_ready[grant_id] SHALL equal !fifo_wfull.
  - All other req_ready bits SHALL be 0.
  - fifo_wren SHALL equal req_valid[grant_id] & !fifo_wfull.
  - fifo_wdata SHALL equal the req_data slice of grant_id.
  - All three SHALL be combinational.
- REQ-009 Outside GRANT, fifo_wren and all req_ready bits SHALL be 0.
- REQ-010 A beat SHALL be counted only when fifo_wren is 1. The beat counter SHALL be 8 bits, SHALL clear on entry to GRANT, and SHALL NOT advance while fifo_wfull is 1.
- REQ-011 GRANT SHALL return to IDLE, and set last_gnt to grant_id, on the first edge where any of these holds:
  - a beat is counted with req_last high;
  - a beat is counted and it is the BURST-th beat;
  - req_valid[grant_id] is 0.
- REQ-012 If the BURST limit and req_last fall on the same beat, the FSM SHALL perform a single release with no extra cycle.
- REQ-013 fifo_wfull high SHALL never cause a release. The owner SHALL hold the grant, stalled, until fifo_wfull falls.
- REQ-014 There SHALL be one dead cycle (IDLE) between consecutive grants, including consecutive grants to the same requester.
- REQ-015 Requesters SHALL hold valid and data stable until accepted. The block SHALL NOT buffer data, and SHALL add no latency from req_data to fifo_wdata.

Reset
- REQ-016 Assertion of rst SHALL immediately force, asynchronously:
  - state = IDLE;
  - beat counter = 0;
  - grant_id = 0;
  - last_gnt = NREQ-1, so requester 0 has first priority;
  - busy = 0, fifo_wren = 0, req_ready = 0.
- REQ-017 Reset asserted mid-burst SHALL abort the grant with no further FIFO write. The FIFO's own reset is the integrator's responsibility.

Configuration
- REQ-018 The macro AFIFO_ARB_STATS_EN, when defined, SHALL add output port stat_beats, NREQ*16 bits. Each 16-bit field SHALL count the accepted beats of its requester, saturate at 0xFFFF, and reset to 0.
- REQ-019 Without AFIFO_ARB_STATS_EN, the stat_beats port and its counters SHALL be absent, and the remaining function SHALL be identical.

Structure
- REQ-020 Package afifo_arb_pkg SHALL hold:
  - the state enum (IDLE, GRANT);
  - the beat-counter width constant (8);
  - the stats counter width constant (16).
- REQ-021 Combinational sub-module rr_pick SHALL take (req vector, last_gnt) and return (any, winner index). It SHALL be the only round-robin logic in the block.

Verification
- REQ-022 Reset release, then req_valid=4'b0001 with req_last=1 on the first beat:
  - grant_id=0 and busy=1 one cycle later;
  - exactly one fifo_wren pulse;
  - IDLE on the following cycle.
- REQ-023 All four requesters continuously valid, req_last never high, BURST=4:
  - grants in order 0,1,2,3,0;
  - each grant writes 4 beats;
  - one idle cycle between grants.
- REQ-024 Requester 2 granted, fifo_wfull high for 5 cycles mid-burst:
  - fifo_wren=0 and req_ready=0 for those cycles;
  - grant held;
  - beat count resumes at the same value;
  - total beats = 4.
- REQ-025 Requester 1 drops req_valid after 2 beats: release to IDLE on that edge, and the next grant goes to the next pending requester above 1.
- REQ-026 rst asserted during beat 2 of a grant to requester 3:
  - fifo_wren=0 immediately;
  - after release, requester 0 wins first when all requesters are valid.
- REQ-027 With AFIFO_ARB_STATS_EN defined, after the REQ-023 run of 5 grants: stat_beats fields = 8,4,4,4 for requesters 0..3.
